// File: rtl/forth_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : forth_stack_ctrl
// Purpose  : Forth stack engine with TOS register and RAM spill/fill
// Revision : 1.0
// ============================================================================
module forth_stack_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  empty,
  output logic                  full,
  output logic                  ready,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH:0]   C_MAX      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   C_DEP_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   C_DEP_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_ADR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] C_ADR_TWO  = {{(ADDR_WIDTH-2){1'b0}}, 2'b10};

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_tos, w_tos_nxt;
  logic [ADDR_WIDTH:0]   r_depth, w_depth_nxt;
  logic                  r_ovf, r_unf;
  logic                  w_ovf_set, w_unf_set;
  logic                  w_we;
  logic                  w_empty, w_full;

  assign w_empty = (r_depth == C_DEP_ZERO);
  assign w_full  = (r_depth == C_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_tos_nxt   = r_tos;
    w_depth_nxt = r_depth;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Push+pop on an empty stack degenerates to a plain push.
        if (push && (!pop || w_empty)) begin
          if (w_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_we        = !w_empty;
            w_tos_nxt   = din;
            w_depth_nxt = r_depth + C_DEP_ONE;
          end
        end else if (push && pop) begin
          w_tos_nxt = din;
        end else if (pop) begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else if (r_depth == C_DEP_ONE) begin
            w_tos_nxt   = '0;
            w_depth_nxt = C_DEP_ZERO;
          end else begin
            w_depth_nxt = r_depth - C_DEP_ONE;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        w_tos_nxt   = mem_q;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tos   <= '0;
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tos   <= w_tos_nxt;
      r_depth <= w_depth_nxt;
      // An error event in the same cycle as clear_err leaves its flag set.
      r_ovf   <= w_ovf_set | (r_ovf & ~clear_err);
      r_unf   <= w_unf_set | (r_unf & ~clear_err);
    end
  end

  assign tos            = r_tos;
  assign depth          = r_depth;
  assign empty          = w_empty;
  assign full           = w_full;
  assign ready          = (r_state == S_IDLE);
  assign overflow       = r_ovf;
  assign underflow      = r_unf;
  assign mem_data       = r_tos;
  assign mem_we         = w_we;
  assign mem_write_addr = r_depth[ADDR_WIDTH-1:0] - C_ADR_ONE;
  assign mem_read_addr  = r_depth[ADDR_WIDTH-1:0] - C_ADR_TWO;

endmodule
`default_nettype wire

// File: tb/tb_forth_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_forth_stack_ctrl
// Purpose  : Randomized self-checking bench against a queue-based stack model
// Revision : 1.0
// ============================================================================
module tb_forth_stack_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int MAX = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clear_err = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] tos, mem_data, mem_q;
  logic [AW:0]   depth;
  logic          empty, full, ready, overflow, underflow, mem_we;
  logic [AW-1:0] mem_write_addr, mem_read_addr;

  logic [DW-1:0] ram [0:MAX-1];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bottom of stack at index 0, visible TOS kept separately
  logic [DW-1:0] m_stk[$];
  logic [DW-1:0] m_tos;
  bit            m_fetch, m_ovf, m_unf;

  forth_stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .din(din),
    .clear_err(clear_err), .tos(tos), .depth(depth), .empty(empty),
    .full(full), .ready(ready), .overflow(overflow), .underflow(underflow),
    .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_we(mem_we),
    .mem_read_addr(mem_read_addr), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // Dual-port RAM with registered read
  always @(posedge clock) begin
    if (mem_we) ram[mem_write_addr] <= mem_data;
    mem_q <= ram[mem_read_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    int d;
    bit exp_we;
    d      = m_stk.size();
    exp_we = !m_fetch && push && !pop && d >= 1 && d < MAX;
    check_val("tos",       32'(tos),            32'(m_tos));
    check_val("depth",     32'(depth),          32'(d));
    check_val("empty",     32'(empty),          32'(d == 0));
    check_val("full",      32'(full),           32'(d == MAX));
    check_val("ready",     32'(ready),          32'(!m_fetch));
    check_val("overflow",  32'(overflow),       32'(m_ovf));
    check_val("underflow", 32'(underflow),      32'(m_unf));
    check_val("mem_we",    32'(mem_we),         32'(exp_we));
    check_val("mem_data",  32'(mem_data),       32'(m_tos));
    check_val("waddr",     32'(mem_write_addr), 32'((d + MAX - 1) % MAX));
    check_val("raddr",     32'(mem_read_addr),  32'((d + MAX - 2) % MAX));
  endtask

  task automatic model_tick();
    int  d;
    bit  ovf_ev, unf_ev;
    d      = m_stk.size();
    ovf_ev = 0;
    unf_ev = 0;
    if (m_fetch) begin
      m_fetch = 0;
      m_tos   = m_stk[$];
    end else if (push && pop && d >= 1) begin
      m_stk[d-1] = din;
      m_tos      = din;
    end else if (push) begin
      if (d == MAX) ovf_ev = 1;
      else begin
        m_stk.push_back(din);
        m_tos = din;
      end
    end else if (pop) begin
      if (d == 0) unf_ev = 1;
      else begin
        void'(m_stk.pop_back());
        if (d == 1) m_tos = '0;
        else m_fetch = 1;
      end
    end
    m_ovf = ovf_ev || (m_ovf && !clear_err);
    m_unf = unf_ev || (m_unf && !clear_err);
  endtask

  task automatic step(input bit p, input bit o, input logic [DW-1:0] d, input bit c);
    push = p; pop = o; din = d; clear_err = c;
    @(negedge clock);
    compare_all();
    @(posedge clock);
    model_tick();
    #1;
  endtask

  task automatic do_reset();
    push = 0; pop = 0; clear_err = 0; din = '0;
    reset = 1'b1;
    #2;
    m_stk.delete();
    m_tos = '0; m_fetch = 0; m_ovf = 0; m_unf = 0;
    compare_all();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    @(posedge clock); #1;

    // Three consecutive pushes spill the older values to RAM
    step(1, 0, 16'h1111, 0);
    step(1, 0, 16'h2222, 0);
    step(1, 0, 16'h3333, 0);
    step(0, 0, 16'h0000, 0);
    check_val("ram0", 32'(ram[0]), 32'h1111);
    check_val("ram1", 32'(ram[1]), 32'h2222);

    // Two fills, then pop down to empty and underflow
    step(0, 1, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h0, 0);
    step(0, 1, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);

    // Replace at depth 2
    step(1, 0, 16'hAAAA, 0);
    step(1, 0, 16'h5555, 0);
    step(1, 1, 16'hBEEF, 0);
    step(0, 0, 16'h0, 0);

    // Fill to capacity, overflow, replace while full
    do_reset();
    for (int i = 0; i < MAX; i++) step(1, 0, DW'($urandom), 0);
    step(1, 0, 16'hDEAD, 0);
    step(0, 0, 16'h0, 0);
    check_val("ram1022", 32'(ram[MAX-2]), 32'(m_stk[MAX-2]));
    step(1, 1, 16'hCAFE, 0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);

    // Reset during a fill
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, DW'(16'h0100 + i), 0);
    step(0, 1, 16'h0, 0);
    do_reset();
    step(0, 0, 16'h0, 0);

    // Push presented during the fill cycle is ignored
    for (int i = 0; i < 5; i++) step(1, 0, DW'(16'h0200 + i), 0);
    step(0, 1, 16'h0, 0);
    step(1, 0, 16'h7777, 0);
    step(0, 0, 16'h0, 0);
    check_val("depth_after_ign", 32'(depth), 32'd4);

    // Random traffic: drain-biased from a full stack, then mixed
    do_reset();
    for (int i = 0; i < MAX - 8; i++) step(1, 0, DW'($urandom), 0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit p, o;
      r = $urandom_range(0, 99);
      if (i < 1500) begin
        p = (r < 20) || (r >= 90);
        o = (r >= 20);
      end else begin
        p = (r < 50) || (r >= 90);
        o = (r >= 45);
      end
      step(p, o, DW'($urandom), ($urandom_range(0, 15) == 0));
    end
    step(0, 0, 16'h0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/forth_stack_ctrl.md
# forth_stack_ctrl

Stack engine that drives a simple dual-port `memoria` RAM (16-bit data, 10-bit address) as the backing store of a Forth data or return stack. It holds the top-of-stack (TOS) in a register and spills or fills deeper entries through the RAM's write and read ports. It absorbs the RAM's one-cycle registered read latency with a small state machine and a `ready` handshake. The integrator ties both RAM clocks (`read_clock`, `write_clock`) to `clock`.

## Interface
- `DATA_WIDTH`, 16, stack word width; must match the RAM
- `ADDR_WIDTH`, 10, RAM address width; stack capacity is 2**ADDR_WIDTH words in total (TOS register plus RAM)
- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `push`  in  1  push `din` (accepted only when `ready`=1)
- `pop`  in  1  discard TOS (accepted only when `ready`=1)
- `din`  in  DATA_WIDTH  value to push
- `clear_err`  in  1  synchronous clear of the sticky error flags
- `tos`  out  DATA_WIDTH  current top of stack (registered)
- `depth`  out  ADDR_WIDTH+1  number of valid entries, 0..2**ADDR_WIDTH
- `empty`, `full`  out  1  `depth`==0 / `depth`==2**ADDR_WIDTH
- `ready`  out  1  command accepted this cycle if asserted
- `overflow`, `underflow`  out  1  sticky error flags
- `mem_data`  out  DATA_WIDTH  to RAM `data`; always equals `tos`
- `mem_write_addr`  out  ADDR_WIDTH  to RAM `write_addr`; `depth`-1 modulo 2**ADDR_WIDTH
- `mem_we`  out  1  to RAM `we`
- `mem_read_addr`  out  ADDR_WIDTH  to RAM `read_addr`; `depth`-2 modulo 2**ADDR_WIDTH
- `mem_q`  in  DATA_WIDTH  from RAM `q`; valid one clock after the address is sampled

## Operation
- Storage layout:
  - When `depth`>=1, TOS lives in the `tos` register.
  - Entry k from the bottom of the stack (k = 0 .. `depth`-2) lives at RAM address k.
- States:
  - IDLE: `ready`=1.
  - FETCH: `ready`=0; lasts exactly one cycle, then returns to IDLE.
- Commands in IDLE, evaluated with the current `depth`:
  - push only, `depth`==0: `tos`<=`din`; `depth`<=1; no RAM write.
  - push only, 1<=`depth`<max: `mem_we`=1, which writes the old `tos` to address `depth`-1; `tos`<=`din`; `depth`++.
  - push only, full: no change; `overflow`<=1.
  - pop only, `depth`==0: no change; `underflow`<=1.
  - pop only, `depth`==1: `tos`<=0; `depth`<=0; stay in IDLE.
  - pop only, `depth`>=2: RAM samples `mem_read_addr` (=`depth`-2) at this edge; `depth`--; go to FETCH.
  - push and pop together, `depth`>=1: replace TOS (`tos`<=`din`); `depth` unchanged; no RAM access; no error, even when full.
  - push and pop together, `depth`==0: treated as push only.
- FETCH: `tos`<=`mem_q`; go to IDLE.
- Commands presented while `ready`=0 are ignored entirely: no state change, no error flag.
- `mem_we` is combinational. It is 1 only for an accepted push-only in IDLE with 1<=`depth`<max; otherwise 0, including in FETCH.
- `clear_err` zeroes both flags. If an error event and `clear_err` occur in the same cycle, the error event wins (flag set).

## Timing
- Reset values: `tos`=0, `depth`=0, `empty`=1, `full`=0, `ready`=1, `overflow`=0, `underflow`=0, `mem_we`=0; state IDLE.
- A reset asserted mid-FETCH aborts the fill; the RAM contents are left as-is and are don't-care.
- Push latency: `tos`/`depth` update at the accepting edge. Back-to-back pushes sustain one per cycle.
- Pop with `depth`>=2, accepted in cycle N:
  - `depth` decrements at the end of N.
  - `ready`=0 in N+1.
  - New `tos` is visible from N+2.
  - Throughput is one such pop per 2 cycles.
- Pop with `depth`<=1 and replace: one cycle, `ready` stays 1.
- `empty`, `full`, `mem_read_addr`, `mem_write_addr` and `mem_data` are combinational from registered state.
- A RAM write issued in cycle N is readable by a pop issued in N+1, because the write occurs at the end of N.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles -> RAM[0]=0x1111, RAM[1]=0x2222, `tos`=0x3333, `depth`=3, `mem_we` high in cycles 2 and 3 only.
- From that state, pop twice as soon as `ready` allows -> `tos`=0x2222 two cycles after the first pop and 0x1111 two cycles after the second pop; `ready` low exactly one cycle after each pop; `depth`=1.
- Pop at `depth`=1, then pop again -> `tos`=0, `depth`=0, `empty`=1; second pop sets `underflow`=1 with `depth` still 0; `clear_err` clears the flag next edge.
- Push and pop together with `din`=0xBEEF at `depth`=2 -> `tos`=0xBEEF, `depth`=2, `mem_we`=0, `ready` stays 1.
- Fill to 1024 entries (ADDR_WIDTH=10), then push once more -> `full`=1, `overflow`=1, `tos` and RAM[1022] unchanged; push and pop together while full replaces `tos` with no error.
- Pop at `depth`=5, assert `reset` during the FETCH cycle, and hold `push`=1 during FETCH in a separate run -> after reset all outputs at reset values and state IDLE; in the separate run, the push is ignored and `depth` stays 4.
